// File: rtl/seq_microstep_p_if.sv
// seq_microstep_p_if: panel-control inputs and phase/status outputs of the
// microstep sequencer. Signal prefixes are from the sequencer's point of
// view (i_ = into the sequencer, o_ = out of it). NEXEC must match the
// sequencer instance it is connected to.
interface seq_microstep_p_if #(
  parameter int NEXEC = 6
);
  localparam int NPH = 4 + NEXEC;
  localparam int SW  = $clog2(2 * NPH);

  // panel controls and sequencing inputs
  logic             i_clear;
  logic             i_run;
  logic             i_halt;
  logic             i_stepm;
  logic             i_stepi;
  logic [1:0]       i_seqtype;
  logic             i_wait;

  // step counter, phase clocks, strobes and status
  logic [SW-1:0]    o_step;
  logic             o_ph1;
  logic             o_ph2;
  logic [3:0]       o_ck_pre;
  logic [3:0]       o_stb_pre;
  logic [NEXEC-1:0] o_ck_ex;
  logic [NEXEC-1:0] o_stb_ex;
  logic             o_running;
  logic             o_instr_end;

  // front-panel / control side
  modport master (
    output i_clear, i_run, i_halt, i_stepm, i_stepi, i_seqtype, i_wait,
    input  o_step, o_ph1, o_ph2, o_ck_pre, o_stb_pre, o_ck_ex, o_stb_ex,
           o_running, o_instr_end
  );

  // sequencer side
  modport slave (
    input  i_clear, i_run, i_halt, i_stepm, i_stepi, i_seqtype, i_wait,
    output o_step, o_ph1, o_ph2, o_ck_pre, o_stb_pre, o_ck_ex, o_stb_ex,
           o_running, o_instr_end
  );
endinterface

// File: rtl/seq_microstep_p.sv
// seq_microstep_p: parametrised PDP-8 microstep sequencer.
// Steps through FETCH / AUTOINC1 / AUTOINC2 / INDIRECT / EX1..EXn phases,
// two steps per phase, under run/halt/single-instruction/single-microstep
// control. Optional feature macro: SEQ_WAIT_EN (memory wait-state
// stretching on strobe steps); without it the WAIT input is ignored.
module seq_microstep_p #(
  parameter int NEXEC = 6
) (
  input logic              i_clk,
  input logic              i_rst,
  seq_microstep_p_if.slave bus
);

  localparam int NPH  = 4 + NEXEC;
  localparam int LAST = 2 * NPH - 1;
  localparam int SW   = $clog2(2 * NPH);

  localparam logic [SW-1:0] LAST_STEP = SW'(LAST);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_INSTR = 2'd2;
  localparam logic [1:0] S_MICRO = 2'd3;

  logic [SW-1:0]    r_step;
  logic [1:0]       r_state;
  logic             r_halt_pend;
  logic             r_instr_end;
  logic             r_prev_run;
  logic             r_prev_halt;
  logic             r_prev_stepm;
  logic             r_prev_stepi;

  logic             w_run_edge;
  logic             w_halt_edge;
  logic             w_stepm_edge;
  logic             w_stepi_edge;
  logic             w_stall;
  logic             w_adv;
  logic             w_wrap;
  logic [SW-1:0]    w_step_adv;
  logic [SW-1:0]    w_step_next;
  logic [1:0]       w_state_next;
  logic             w_halt_pend_next;
  logic             w_instr_end_next;
  logic [SW-2:0]    w_phase;
  logic [3:0]       w_ck_pre;
  logic [3:0]       w_stb_pre;
  logic [NEXEC-1:0] w_ck_ex;
  logic [NEXEC-1:0] w_stb_ex;

  assign w_run_edge   = bus.i_run   & ~r_prev_run;
  assign w_halt_edge  = bus.i_halt  & ~r_prev_halt;
  assign w_stepm_edge = bus.i_stepm & ~r_prev_stepm;
  assign w_stepi_edge = bus.i_stepi & ~r_prev_stepi;

`ifdef SEQ_WAIT_EN
  // memory wait only stretches strobe (odd) steps
  assign w_stall = bus.i_wait & r_step[0];
`else
  // WAIT is accepted on the port but never stalls the sequence
  assign w_stall = bus.i_wait & 1'b0;
`endif

  assign w_adv  = (r_state != S_IDLE) && !w_stall;
  assign w_wrap = w_adv && (r_step == LAST_STEP);

  // successor step: step 1 branches on SEQTYPE, LAST wraps to FETCH
  always_comb begin
    w_step_adv = r_step + SW'(1);
    if (r_step == LAST_STEP) begin
      w_step_adv = '0;
    end else if (r_step == SW'(1)) begin
      if (bus.i_seqtype[1])      w_step_adv = SW'(2);
      else if (bus.i_seqtype[0]) w_step_adv = SW'(6);
      else                       w_step_adv = SW'(8);
    end
  end

  // next step counter, control state and halt request
  always_comb begin
    w_step_next      = r_step;
    w_state_next     = r_state;
    w_halt_pend_next = r_halt_pend;
    w_instr_end_next = 1'b0;

    // CLEAR ends the instruction immediately and beats both advance and WAIT
    if (bus.i_clear) begin
      w_step_next      = '0;
      w_instr_end_next = 1'b1;
    end else if (w_adv) begin
      w_step_next      = w_step_adv;
      w_instr_end_next = w_wrap;
    end

    case (r_state)
      S_RUN: begin
        if (bus.i_clear) begin
          if (r_halt_pend) begin
            w_state_next     = S_IDLE;
            w_halt_pend_next = 1'b0;
          end else begin
            w_halt_pend_next = w_halt_edge;
          end
        end else if (w_wrap && (r_halt_pend || w_halt_edge)) begin
          w_state_next     = S_IDLE;
          w_halt_pend_next = 1'b0;
        end else begin
          w_halt_pend_next = r_halt_pend | w_halt_edge;
        end
      end
      S_INSTR: begin
        if (bus.i_clear || w_wrap) w_state_next = S_IDLE;
      end
      S_MICRO: begin
        if (bus.i_clear || w_adv) w_state_next = S_IDLE;
      end
      default: begin
        // idle: run beats step-instruction beats step-microstep; halt ignored
        if (w_run_edge)        w_state_next = S_RUN;
        else if (w_stepi_edge) w_state_next = S_INSTR;
        else if (w_stepm_edge) w_state_next = S_MICRO;
      end
    endcase
  end

  // state registers, edge-detect history and instruction-end pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_step       <= '0;
      r_state      <= S_IDLE;
      r_halt_pend  <= 1'b0;
      r_instr_end  <= 1'b0;
      r_prev_run   <= 1'b0;
      r_prev_halt  <= 1'b0;
      r_prev_stepm <= 1'b0;
      r_prev_stepi <= 1'b0;
    end else begin
      r_step       <= w_step_next;
      r_state      <= w_state_next;
      r_halt_pend  <= w_halt_pend_next;
      r_instr_end  <= w_instr_end_next;
      r_prev_run   <= bus.i_run;
      r_prev_halt  <= bus.i_halt;
      r_prev_stepm <= bus.i_stepm;
      r_prev_stepi <= bus.i_stepi;
    end
  end

  // phase index is the step with the strobe bit dropped
  assign w_phase = r_step[SW-1:1];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pre
      assign w_ck_pre[gi]  = (w_phase == (SW-1)'(gi));
      assign w_stb_pre[gi] = w_ck_pre[gi] & r_step[0];
    end
    for (gi = 0; gi < NEXEC; gi++) begin : g_ex
      assign w_ck_ex[gi]  = (w_phase == (SW-1)'(gi + 4));
      assign w_stb_ex[gi] = w_ck_ex[gi] & r_step[0];
    end
  endgenerate

  assign bus.o_step      = r_step;
  assign bus.o_ph1       = ~r_step[0];
  assign bus.o_ph2       = r_step[0];
  assign bus.o_ck_pre    = w_ck_pre;
  assign bus.o_stb_pre   = w_stb_pre;
  assign bus.o_ck_ex     = w_ck_ex;
  assign bus.o_stb_ex    = w_stb_ex;
  assign bus.o_running   = (r_state != S_IDLE);
  assign bus.o_instr_end = r_instr_end;

endmodule
